// File: rtl/unzip_fork_if.sv
// Handshake bundle for the unzip fork: one interleaved input stream and
// two per-lane output streams with their occupancy levels.
interface unzip_fork_if #(
    parameter int W  = 8,
    parameter int AW = 2
);
    logic             s_valid;
    logic             s_ready;
    logic [2*W-1:0]   s_data;
    logic             swap;

    logic             a_valid;
    logic             a_ready;
    logic [W-1:0]     a_data;
    logic [AW:0]      a_level;

    logic             b_valid;
    logic             b_ready;
    logic [W-1:0]     b_data;
    logic [AW:0]      b_level;

    // Producer of input words and consumer of both lanes
    modport master (
        output s_valid, s_data, swap, a_ready, b_ready,
        input  s_ready, a_valid, a_data, a_level, b_valid, b_data, b_level
    );

    // The fork itself
    modport slave (
        input  s_valid, s_data, swap, a_ready, b_ready,
        output s_ready, a_valid, a_data, a_level, b_valid, b_data, b_level
    );
endinterface

// File: rtl/unzip_fork_fifo_sync.sv
// Single-clock FIFO for one output lane. Occupancy is held in its own
// counter so full and empty are never confused when pointers coincide.
module fifo_sync #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          ready,
    output logic          valid,
    output logic [W-1:0]  dout,
    output logic [AW:0]   level
);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   level_reg;
    logic [AW:0]   level_next;
    logic          push_ok;
    logic          pop_ok;

    // Pops on an empty lane and pushes into a full lane are ignored
    assign pop_ok  = ready && (level_reg != '0);
    assign push_ok = push && (level_reg != FULL_LVL);

    // Occupancy follows push/pop; simultaneous push and pop keep it steady
    always_comb begin
        level_next = level_reg;
        case ({push_ok, pop_ok})
            2'b10:   level_next = level_reg + (AW+1)'(1);
            2'b01:   level_next = level_reg - (AW+1)'(1);
            default: level_next = level_reg;
        endcase
    end

    // Pointer and level state; reset discards all buffered entries
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            level_reg <= level_next;
        end
    end

    // Storage is not reset; contents only matter while valid is high
    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr_reg] <= din;
    end

    // Head word is a mux on the registered read pointer, no fall-through
    assign dout  = mem[rd_ptr_reg];
    assign valid = (level_reg != '0);
    assign level = level_reg;
endmodule

// File: rtl/unzip_fork_unzip.sv
// Combinational bit deinterleaver: even-indexed input bits form one
// half, odd-indexed bits form the other.
module unzip #(
    parameter int W = 8
) (
    input  logic [2*W-1:0] din,
    output logic [W-1:0]   even,
    output logic [W-1:0]   odd
);
    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_bit
            assign even[gi] = din[2*gi];
            assign odd[gi]  = din[2*gi+1];
        end
    endgenerate
endmodule

// File: rtl/unzip_fork.sv
// Streaming fork for the bit deinterleaver: each accepted 2W-bit word is
// split into two W-bit halves that are pushed together into two lane FIFOs.
module unzip_fork #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    unzip_fork_if.slave bus
);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    generate
        if ((DEPTH != (1 << AW)) || (DEPTH < 2)) begin : g_param_check
            $error("unzip_fork: DEPTH must be 2**AW and at least 2");
        end
    endgenerate

    logic [W-1:0] even_bits;
    logic [W-1:0] odd_bits;
    logic [W-1:0] a_din;
    logic [W-1:0] b_din;
    logic [AW:0]  a_level;
    logic [AW:0]  b_level;
    logic         s_ready;
    logic         push;

    unzip #(.W(W)) u_unzip (
        .din  (bus.s_data),
        .even (even_bits),
        .odd  (odd_bits)
    );

    // Lane mapping chosen per word: swap sends odd bits to A, even to B
    always_comb begin
        a_din = even_bits;
        b_din = odd_bits;
        if (bus.swap) begin
            a_din = odd_bits;
            b_din = even_bits;
        end
    end

    // Accept only when both lanes have room so a word is never split;
    // depends on registered levels only, never on the lane readies
    assign s_ready = (a_level != FULL_LVL) && (b_level != FULL_LVL);
    assign push    = bus.s_valid && s_ready;

    fifo_sync #(.W(W), .DEPTH(DEPTH), .AW(AW)) u_fifo_a (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (push),
        .din     (a_din),
        .ready   (bus.a_ready),
        .valid   (bus.a_valid),
        .dout    (bus.a_data),
        .level   (a_level)
    );

    fifo_sync #(.W(W), .DEPTH(DEPTH), .AW(AW)) u_fifo_b (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (push),
        .din     (b_din),
        .ready   (bus.b_ready),
        .valid   (bus.b_valid),
        .dout    (bus.b_data),
        .level   (b_level)
    );

    assign bus.s_ready = s_ready;
    assign bus.a_level = a_level;
    assign bus.b_level = b_level;
endmodule

// File: tb/tb_unzip_fork.sv
// Directed bench for unzip_fork: inputs change on the falling edge and
// outputs are compared on the falling edge, away from the active edge.
module tb_unzip_fork;
    localparam int W     = 8;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    unzip_fork_if #(.W(W), .AW(AW)) bus ();

    unzip_fork #(.W(W), .DEPTH(DEPTH), .AW(AW)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference split: returns {odd_half, even_half}
    function automatic logic [2*W-1:0] ref_split(input logic [2*W-1:0] w);
        logic [2*W-1:0] r;
        r = '0;
        for (int i = 0; i < W; i++) begin
            r[i]     = w[2*i];
            r[W + i] = w[2*i + 1];
        end
        return r;
    endfunction

    // Directed words: data, expected A half, expected B half (swap = 0)
    logic [15:0] t3_w [6] = '{16'h9999, 16'h6666, 16'h000F, 16'hAAAA, 16'h5555, 16'h3333};
    logic [7:0]  t3_a [6] = '{8'h55, 8'hAA, 8'h03, 8'h00, 8'hFF, 8'h55};
    logic [7:0]  t3_b [6] = '{8'hAA, 8'h55, 8'h03, 8'hFF, 8'h00, 8'h55};
    logic [15:0] t4_w [4] = '{16'h0000, 16'hFFFF, 16'h9999, 16'h6666};
    logic [7:0]  t4_a [4] = '{8'hFF, 8'h55, 8'hAA, 8'h03};
    logic [7:0]  t4_b [4] = '{8'hFF, 8'hAA, 8'h55, 8'h03};

    logic [7:0] qa [$];
    logic [7:0] qb [$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int a_idx;
        int cyc;
        int sent;
        bit acc;
        bit done;
        logic [15:0] w;
        logic [15:0] sp;
        logic [7:0] ea;
        logic [7:0] eb;

        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.swap    = 1'b0;
        bus.a_ready = 1'b0;
        bus.b_ready = 1'b0;

        // ---- 1: reset state, then one word with swap = 0
        repeat (2) @(negedge clock);
        chk("rst_a_valid", bus.a_valid, 0);
        chk("rst_b_valid", bus.b_valid, 0);
        chk("rst_a_level", bus.a_level, 0);
        chk("rst_b_level", bus.b_level, 0);
        chk("rst_s_ready", bus.s_ready, 1);
        reset_n = 1'b1;
        @(negedge clock);
        chk("idle_a_valid", bus.a_valid, 0);
        bus.s_valid = 1'b1; bus.s_data = 16'hAAAA; bus.swap = 1'b0;
        bus.a_ready = 1'b1; bus.b_ready = 1'b1;
        @(negedge clock);
        bus.s_valid = 1'b0;
        chk("t1_a_valid", bus.a_valid, 1);
        chk("t1_b_valid", bus.b_valid, 1);
        chk("t1_a_data",  bus.a_data, 8'h00);
        chk("t1_b_data",  bus.b_data, 8'hFF);
        chk("t1_a_level", bus.a_level, 1);
        chk("t1_b_level", bus.b_level, 1);
        @(negedge clock);
        chk("t1_a_level0", bus.a_level, 0);
        chk("t1_b_level0", bus.b_level, 0);
        chk("t1_a_valid0", bus.a_valid, 0);

        // ---- 2: swap = 1
        bus.s_valid = 1'b1; bus.s_data = 16'h5555; bus.swap = 1'b1;
        @(negedge clock);
        bus.s_valid = 1'b0; bus.swap = 1'b0;
        chk("t2_a_data", bus.a_data, 8'h00);
        chk("t2_b_data", bus.b_data, 8'hFF);
        @(negedge clock);
        chk("t2_levels", {bus.a_level, bus.b_level}, 0);

        // ---- 3: lane B stalled, lane A flowing
        bus.a_ready = 1'b1; bus.b_ready = 1'b0;
        idx = 0; a_idx = 0; cyc = 0;
        while (idx < 4 && cyc < 20) begin
            bus.s_valid = 1'b1;
            bus.s_data  = t3_w[idx];
            acc = bus.s_ready;
            @(negedge clock);
            cyc++;
            if (acc) idx++;
            if (bus.a_valid) begin
                chk("t3_a_data", bus.a_data, t3_a[a_idx]);
                a_idx++;
            end
        end
        chk("t3_accepts", idx, 4);
        bus.s_data = t3_w[4];
        for (int k = 0; k < 3; k++) begin
            chk("t3_s_ready_full", bus.s_ready, 0);
            chk("t3_b_level_full", bus.b_level, 4);
            @(negedge clock);
            if (bus.a_valid) begin
                chk("t3_a_data", bus.a_data, t3_a[a_idx]);
                a_idx++;
            end
        end
        chk("t3_a_level_drained", bus.a_level, 0);
        chk("t3_a_count", a_idx, 4);
        bus.s_valid = 1'b0;
        bus.b_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("t3_b_valid", bus.b_valid, 1);
            chk("t3_b_data", bus.b_data, t3_b[k]);
            @(negedge clock);
        end
        chk("t3_b_level0", bus.b_level, 0);
        bus.s_valid = 1'b1; bus.s_data = t3_w[4];
        @(negedge clock);
        chk("t3_w4_a", bus.a_data, t3_a[4]);
        chk("t3_w4_b", bus.b_data, t3_b[4]);
        bus.s_data = t3_w[5];
        @(negedge clock);
        bus.s_valid = 1'b0;
        chk("t3_w5_a", bus.a_data, t3_a[5]);
        chk("t3_w5_b", bus.b_data, t3_b[5]);
        @(negedge clock);
        chk("t3_end_levels", {bus.a_level, bus.b_level}, 0);

        // ---- 4: both full, pop and push offered in the same cycle
        bus.a_ready = 1'b0; bus.b_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.s_valid = 1'b1; bus.s_data = t4_w[k];
            @(negedge clock);
        end
        bus.s_data = 16'h000F;
        chk("t4_full_a", bus.a_level, 4);
        chk("t4_full_b", bus.b_level, 4);
        chk("t4_full_s_ready", bus.s_ready, 0);
        bus.a_ready = 1'b1; bus.b_ready = 1'b1;
        @(negedge clock);
        chk("t4_after_pop_a", bus.a_level, 3);
        chk("t4_after_pop_b", bus.b_level, 3);
        chk("t4_resume_s_ready", bus.s_ready, 1);
        chk("t4_head_a", bus.a_data, 8'hFF);
        bus.a_ready = 1'b0; bus.b_ready = 1'b0;
        @(negedge clock);
        bus.s_valid = 1'b0;
        chk("t4_refill_a", bus.a_level, 4);
        chk("t4_refill_b", bus.b_level, 4);
        bus.a_ready = 1'b1; bus.b_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("t4_drain_a", bus.a_data, t4_a[k]);
            chk("t4_drain_b", bus.b_data, t4_b[k]);
            @(negedge clock);
        end
        chk("t4_end_levels", {bus.a_level, bus.b_level}, 0);

        // ---- 5: wrap-around with random readies and random swap
        sent = 0; cyc = 0; done = 0;
        qa.delete(); qb.delete();
        w = 16'($urandom_range(0, 65535));
        while (!done && cyc < 400) begin
            chk("t5_a_level", bus.a_level, qa.size());
            chk("t5_b_level", bus.b_level, qb.size());
            bus.a_ready = ($urandom_range(0, 2) != 0);
            bus.b_ready = ($urandom_range(0, 2) != 0);
            if (bus.a_valid && bus.a_ready) begin
                ea = qa.pop_front();
                chk("t5_a_data", bus.a_data, ea);
            end
            if (bus.b_valid && bus.b_ready) begin
                eb = qb.pop_front();
                chk("t5_b_data", bus.b_data, eb);
            end
            if (sent < 3 * DEPTH) begin
                if (!bus.s_valid) begin
                    w = 16'($urandom_range(0, 65535));
                    bus.swap = 1'($urandom_range(0, 1));
                end
                bus.s_valid = 1'b1;
                bus.s_data  = w;
                if (bus.s_ready) begin
                    sp = ref_split(w);
                    if (bus.swap) begin
                        qa.push_back(sp[15:8]);
                        qb.push_back(sp[7:0]);
                    end else begin
                        qa.push_back(sp[7:0]);
                        qb.push_back(sp[15:8]);
                    end
                    sent++;
                    // force a fresh word next cycle
                    @(negedge clock);
                    bus.s_valid = 1'b0;
                    cyc++;
                    continue;
                end
            end else begin
                bus.s_valid = 1'b0;
                if (qa.size() == 0 && qb.size() == 0) done = 1;
            end
            @(negedge clock);
            cyc++;
        end
        chk("t5_done", done, 1);
        chk("t5_sent", sent, 3 * DEPTH);
        bus.s_valid = 1'b0; bus.swap = 1'b0;
        bus.a_ready = 1'b1; bus.b_ready = 1'b1;
        @(negedge clock);
        chk("t5_end_levels", {bus.a_level, bus.b_level}, 0);

        // ---- 6: reset mid-stream with two words buffered per lane
        bus.a_ready = 1'b0; bus.b_ready = 1'b0;
        bus.s_valid = 1'b1; bus.s_data = 16'h3333;
        @(negedge clock);
        bus.s_data = 16'h0000;
        @(negedge clock);
        bus.s_valid = 1'b0;
        chk("t6_pre_a_level", bus.a_level, 2);
        chk("t6_pre_b_level", bus.b_level, 2);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_rst_a_level", bus.a_level, 0);
        chk("t6_rst_b_level", bus.b_level, 0);
        chk("t6_rst_valids", {bus.a_valid, bus.b_valid}, 0);
        chk("t6_rst_s_ready", bus.s_ready, 1);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        chk("t6_post_valids", {bus.a_valid, bus.b_valid}, 0);
        bus.s_valid = 1'b1; bus.s_data = 16'h9999; bus.swap = 1'b1;
        bus.a_ready = 1'b1; bus.b_ready = 1'b1;
        @(negedge clock);
        bus.s_valid = 1'b0; bus.swap = 1'b0;
        chk("t6_valids", {bus.a_valid, bus.b_valid}, 2'b11);
        chk("t6_a_data", bus.a_data, 8'hAA);
        chk("t6_b_data", bus.b_data, 8'h55);
        @(negedge clock);
        chk("t6_end_levels", {bus.a_level, bus.b_level}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
